// File: rtl/hazard_scheduler_if.sv
// Hazard scheduler bus: ID-stage instruction fields, memory/branch status in,
// pipeline control and forwarding selects out.
//   master : pipeline control side (drives ID fields, memBusy, branchTaken)
//   slave  : hazard_scheduler (drives stall/freeze/flush, selects, state, counter)
interface hazard_scheduler_if #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             forwardEn;
  logic             idValid;
  logic [REG_W-1:0] idSrc1;
  logic [REG_W-1:0] idSrc2;
  logic             idTwoSrc;
  logic             idWbEn;
  logic [REG_W-1:0] idDest;
  logic             idMemRead;
  logic             memBusy;
  logic             branchTaken;
  logic             stall;
  logic             freeze;
  logic             flush;
  logic [1:0]       selSrc1;
  logic [1:0]       selSrc2;
  logic [1:0]       hazState;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output forwardEn, idValid, idSrc1, idSrc2, idTwoSrc, idWbEn, idDest,
           idMemRead, memBusy, branchTaken,
    input  stall, freeze, flush, selSrc1, selSrc2, hazState, stallCount
  );

  modport slave (
    input  forwardEn, idValid, idSrc1, idSrc2, idTwoSrc, idWbEn, idDest,
           idMemRead, memBusy, branchTaken,
    output stall, freeze, flush, selSrc1, selSrc2, hazState, stallCount
  );
endinterface

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: EXE/MEM/WB scoreboard that stalls IF/ID on unresolvable
// RAW hazards, freezes the pipe on SRAM wait states, bubbles EXE on a taken
// branch and drives the EXE operand-forwarding selects.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   hz   : hazard_scheduler_if.slave (ID fields, memBusy, branchTaken in;
//          stall/freeze/flush, selSrc1/2, hazState, stallCount out)
// Optional feature: define HAZ_STALL_CNT_EN to build the saturating
// stall-cycle counter; otherwise stallCount is tied to zero.
module hazard_scheduler #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_scheduler_if.slave hz
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_HAZARD   = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT = 2'b10;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // EXE keeps source fields for forwarding; MEM/WB only need producer info.
  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_read;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
  } exe_entry_t;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic [REG_W-1:0] dest;
  } pipe_entry_t;

  exe_entry_t  exe_q, exe_d, id_entry;
  pipe_entry_t mem_q, mem_d, wb_q, wb_d, exe_as_pipe;
  logic [1:0]  state_q, state_d;
  logic        exe_hit_c, mem_hit_c, hazard_c;
  logic        stall_c, freeze_c, flush_c;
  logic [1:0]  sel1_c, sel2_c;

  // Producer-to-source select: MEM result is younger, so it wins over WB.
  function automatic logic [1:0] fwd_sel(pipe_entry_t m, pipe_entry_t w,
                                         logic [REG_W-1:0] src);
    if (m.valid && m.wb_en && m.dest == src)      return SEL_MEM;
    else if (w.valid && w.wb_en && w.dest == src) return SEL_WB;
    else                                          return SEL_REG;
  endfunction

  // ID instruction as it would enter EXE; bubble when ID is empty.
  always_comb begin
    id_entry = '0;
    if (hz.idValid) begin
      id_entry.valid    = 1'b1;
      id_entry.wb_en    = hz.idWbEn;
      id_entry.mem_read = hz.idMemRead;
      id_entry.dest     = hz.idDest;
      id_entry.src1     = hz.idSrc1;
      id_entry.src2     = hz.idSrc2;
      id_entry.two_src  = hz.idTwoSrc;
    end
  end

  assign exe_as_pipe = '{valid: exe_q.valid, wb_en: exe_q.wb_en, dest: exe_q.dest};

  // RAW detection against EXE and MEM producers; WB writes the file first.
  assign exe_hit_c = exe_q.valid && exe_q.wb_en &&
                     (exe_q.dest == hz.idSrc1 || (hz.idTwoSrc && exe_q.dest == hz.idSrc2));
  assign mem_hit_c = mem_q.valid && mem_q.wb_en &&
                     (mem_q.dest == hz.idSrc1 || (hz.idTwoSrc && mem_q.dest == hz.idSrc2));
  assign hazard_c  = hz.idValid &&
                     (hz.forwardEn ? (exe_hit_c && exe_q.mem_read) : (exe_hit_c || mem_hit_c));

  // Next-state and pipeline control: rst > memBusy > branchTaken > hazard > advance.
  always_comb begin
    exe_d    = exe_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    state_d  = state_q;
    stall_c  = 1'b0;
    freeze_c = 1'b0;
    flush_c  = 1'b0;
    if (rst) begin
      state_d = ST_RUN;
    end else if (hz.memBusy) begin
      stall_c  = 1'b1;
      freeze_c = 1'b1;
      state_d  = ST_MEM_WAIT;
    end else begin
      mem_d = exe_as_pipe;
      wb_d  = mem_q;
      if (hz.branchTaken) begin
        flush_c = 1'b1;
        exe_d   = '0;
        state_d = ST_RUN;
      end else if (hazard_c) begin
        stall_c = 1'b1;
        exe_d   = '0;
        state_d = ST_HAZARD;
      end else begin
        exe_d   = id_entry;
        state_d = ST_RUN;
      end
    end
  end

  // Scoreboard and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q   <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

  // Forwarding selects for the instruction currently in EXE.
  always_comb begin
    sel1_c = SEL_REG;
    sel2_c = SEL_REG;
    if (!rst && hz.forwardEn && exe_q.valid) begin
      sel1_c = fwd_sel(mem_q, wb_q, exe_q.src1);
      if (exe_q.two_src) sel2_c = fwd_sel(mem_q, wb_q, exe_q.src2);
    end
  end

  assign hz.stall    = stall_c;
  assign hz.freeze   = freeze_c;
  assign hz.flush    = flush_c;
  assign hz.selSrc1  = sel1_c;
  assign hz.selSrc2  = sel2_c;
  assign hz.hazState = state_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of stall cycles, freeze cycles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall_c && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hz.stallCount = cnt_q;
`else
  assign hz.stallCount = '0;
`endif

endmodule
